// File: rtl/mmc_seq_controller.sv
// rtl/mmc_seq_controller.sv - power-rail sequencer and SPI register-table configurator with capture control
module mmc_seq_controller #(
    parameter int NUM_RAILS = 2,
    parameter int RAIL_STEP = 2,
    parameter int CFG_LEN   = 55,
    parameter int IDX_W     = 6,
    parameter int CAP_IDX   = 61,
    parameter int SPI_TMO   = 1023
) (
    input  logic                 sys_clk,
    input  logic                 rst,
    input  logic [2:0]           mlc_cmd,
    input  logic                 mlc_en,
    output logic                 mlc_idle,
    output logic                 spi_en,
    output logic                 spi_rd_wr,
    output logic [4:0]           spi_addr,
    output logic [7:0]           spi_data,
    input  logic                 spi_done,
    output logic [IDX_W-1:0]     idx,
    input  logic [4:0]           addr_reg,
    input  logic [7:0]           data_reg,
    output logic [NUM_RAILS-1:0] rail_en,
    input  logic                 cap_done,
    input  logic                 rx_if_rdy,
    output logic                 sh_r,
    output logic                 fault,
    output logic [2:0]           mlc_state
);

    localparam int WD_W = $clog2(SPI_TMO + 1);
    // Leave POWER one cycle early so CONFIG is visible exactly (NUM_RAILS+1)*RAIL_STEP cycles in.
    localparam logic [15:0] CNT_LAST = 16'((NUM_RAILS + 1) * RAIL_STEP - 1);

    typedef enum logic [2:0] {
        ST_OFF    = 3'b000,
        ST_POWER  = 3'b001,
        ST_CONFIG = 3'b010,
        ST_IDLE   = 3'b011,
        ST_CAP    = 3'b100,
        ST_FAULT  = 3'b101
    } state_e;

    state_e                state_q, state_d;
    logic [15:0]           cnt_q, cnt_d;
    logic [NUM_RAILS-1:0]  rail_q, rail_d;
    logic [IDX_W-1:0]      i_q, i_d;
    logic [WD_W-1:0]       wd_q, wd_d;
    logic                  spi_en_q, spi_en_d;
    logic                  busy_q, busy_d;
    logic                  shift_q, shift_d;
    logic                  stop_q, stop_d;
    logic                  sh_r_q, sh_r_d;
    logic                  fault_q, fault_d;

    logic cmd_on, cmd_off, cmd_cap_set, cmd_cap_stop, done_ok;

    assign cmd_on       = mlc_en && (mlc_cmd == 3'b000);
    assign cmd_off      = mlc_en && (mlc_cmd == 3'b001);
    assign cmd_cap_set  = mlc_en && (mlc_cmd == 3'b010);
    assign cmd_cap_stop = mlc_en && (mlc_cmd == 3'b011);
    assign done_ok      = spi_done && busy_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rail_d   = rail_q;
        i_d      = i_q;
        wd_d     = busy_q ? wd_q + WD_W'(1) : '0;
        spi_en_d = 1'b0;
        busy_d   = busy_q;
        shift_d  = shift_q;
        stop_d   = stop_q;
        sh_r_d   = 1'b0;
        fault_d  = fault_q;

        case (state_q)
            ST_OFF: begin
                fault_d = 1'b0;
                if (cmd_on) begin
                    state_d = ST_POWER;
                    cnt_d   = '0;
                    rail_d  = '0;
                end
            end
            ST_POWER: begin
                cnt_d = cnt_q + 16'd1;
                for (int k = 0; k < NUM_RAILS; k++) begin
                    if (cnt_q == 16'((k + 1) * RAIL_STEP)) rail_d[k] = 1'b1;
                end
                if (cnt_q == CNT_LAST) begin
                    state_d  = ST_CONFIG;
                    i_d      = '0;
                    spi_en_d = 1'b1;
                    busy_d   = 1'b1;
                    wd_d     = '0;
                end
            end
            ST_CONFIG: begin
                if (done_ok) begin
                    if (i_q == IDX_W'(CFG_LEN - 1)) begin
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
                        i_d     = '0;
                    end else begin
                        i_d      = i_q + IDX_W'(1);
                        spi_en_d = 1'b1;
                        busy_d   = 1'b1;
                        wd_d     = '0;
                    end
                end
            end
            ST_IDLE: begin
                if (cmd_cap_set) begin
                    state_d  = ST_CAP;
                    shift_d  = 1'b0;
                    stop_d   = 1'b0;
                    spi_en_d = 1'b1;
                    busy_d   = 1'b1;
                    wd_d     = '0;
                end
            end
            ST_CAP: begin
                if (!shift_q) begin
                    // Arm phase: a stop request is held until the arm write completes.
                    if (done_ok) begin
                        busy_d = 1'b0;
                        if (stop_q || cmd_cap_stop) begin
                            state_d = ST_IDLE;
                            stop_d  = 1'b0;
                        end else begin
                            shift_d = 1'b1;
                        end
                    end else if (cmd_cap_stop) begin
                        stop_d = 1'b1;
                    end
                end else begin
                    sh_r_d = sh_r_q ^ rx_if_rdy;
                    if (cmd_cap_stop) begin
                        state_d = ST_IDLE;
                        shift_d = 1'b0;
                        sh_r_d  = 1'b0;
                    end else if (cap_done) begin
                        state_d  = ST_CONFIG;
                        shift_d  = 1'b0;
                        sh_r_d   = 1'b0;
                        i_d      = '0;
                        spi_en_d = 1'b1;
                        busy_d   = 1'b1;
                        wd_d     = '0;
                    end
                end
            end
            ST_FAULT: begin
                fault_d = 1'b1;
            end
            default: state_d = ST_OFF;
        endcase

        if (busy_q && !spi_done && (wd_q == WD_W'(SPI_TMO))) begin
            state_d  = ST_FAULT;
            fault_d  = 1'b1;
            rail_d   = '0;
            i_d      = '0;
            wd_d     = '0;
            spi_en_d = 1'b0;
            busy_d   = 1'b0;
            shift_d  = 1'b0;
            stop_d   = 1'b0;
            sh_r_d   = 1'b0;
        end

        // OFF outranks everything, including a completion arriving in the same cycle.
        if (cmd_off && (state_q != ST_OFF)) begin
            state_d  = ST_OFF;
            fault_d  = 1'b0;
            rail_d   = '0;
            cnt_d    = '0;
            i_d      = '0;
            wd_d     = '0;
            spi_en_d = 1'b0;
            busy_d   = 1'b0;
            shift_d  = 1'b0;
            stop_d   = 1'b0;
            sh_r_d   = 1'b0;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_q  <= ST_OFF;
            cnt_q    <= '0;
            rail_q   <= '0;
            i_q      <= '0;
            wd_q     <= '0;
            spi_en_q <= 1'b0;
            busy_q   <= 1'b0;
            shift_q  <= 1'b0;
            stop_q   <= 1'b0;
            sh_r_q   <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rail_q   <= rail_d;
            i_q      <= i_d;
            wd_q     <= wd_d;
            spi_en_q <= spi_en_d;
            busy_q   <= busy_d;
            shift_q  <= shift_d;
            stop_q   <= stop_d;
            sh_r_q   <= sh_r_d;
            fault_q  <= fault_d;
        end
    end

    assign mlc_state = state_q;
    assign mlc_idle  = (state_q == ST_IDLE);
    assign spi_en    = spi_en_q;
    assign spi_rd_wr = 1'b0;
    assign idx       = (state_q == ST_CAP) ? IDX_W'(CAP_IDX) : i_q;
    assign spi_addr  = addr_reg;
    assign spi_data  = data_reg;
    assign rail_en   = rail_q;
    assign sh_r      = sh_r_q;
    assign fault     = fault_q;

endmodule

// File: tb/tb_mmc_seq_controller.sv
// tb/tb_mmc_seq_controller.sv - directed self-checking bench for mmc_seq_controller
module tb_mmc_seq_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] mlc_cmd = 3'b000;
    logic       mlc_en = 1'b0;
    logic       mlc_idle, spi_en, spi_rd_wr;
    logic [4:0] spi_addr, addr_reg;
    logic [7:0] spi_data, data_reg;
    logic       spi_done;
    logic [5:0] idx;
    logic [1:0] rail_en;
    logic       cap_done = 1'b0;
    logic       rx_if_rdy = 1'b0;
    logic       sh_r, fault;
    logic [2:0] mlc_state;

    logic [2:0] s_cmd = 3'b000;
    logic       s_en = 1'b0;
    logic       s_idle, s_spi_en, s_rd_wr, s_spi_done, s_sh_r, s_fault;
    logic [4:0] s_spi_addr, s_addr_reg;
    logic [7:0] s_spi_data, s_data_reg;
    logic [5:0] s_idx;
    logic [3:0] s_rail;
    logic [2:0] s_state;

    int checks = 0;
    int errors = 0;
    int hold_idx = -1;
    int resp_cnt = -1;
    logic s_pend = 1'b0;

    always #5 clk = ~clk;

    assign addr_reg   = idx[4:0];
    assign data_reg   = {2'b10, idx};
    assign s_addr_reg = s_idx[4:0];
    assign s_data_reg = {2'b01, s_idx};

    mmc_seq_controller u_dut (
        .sys_clk(clk), .rst(rst), .mlc_cmd(mlc_cmd), .mlc_en(mlc_en), .mlc_idle(mlc_idle),
        .spi_en(spi_en), .spi_rd_wr(spi_rd_wr), .spi_addr(spi_addr), .spi_data(spi_data),
        .spi_done(spi_done), .idx(idx), .addr_reg(addr_reg), .data_reg(data_reg),
        .rail_en(rail_en), .cap_done(cap_done), .rx_if_rdy(rx_if_rdy), .sh_r(sh_r),
        .fault(fault), .mlc_state(mlc_state)
    );

    mmc_seq_controller #(.NUM_RAILS(4), .RAIL_STEP(1), .CFG_LEN(3)) u_small (
        .sys_clk(clk), .rst(rst), .mlc_cmd(s_cmd), .mlc_en(s_en), .mlc_idle(s_idle),
        .spi_en(s_spi_en), .spi_rd_wr(s_rd_wr), .spi_addr(s_spi_addr), .spi_data(s_spi_data),
        .spi_done(s_spi_done), .idx(s_idx), .addr_reg(s_addr_reg), .data_reg(s_data_reg),
        .rail_en(s_rail), .cap_done(1'b0), .rx_if_rdy(1'b0), .sh_r(s_sh_r),
        .fault(s_fault), .mlc_state(s_state)
    );

    // SPI slave model: completion three cycles after each write start unless idx is being held.
    initial begin
        spi_done = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            spi_done = 1'b0;
            if (resp_cnt > 0) begin
                resp_cnt--;
                if (resp_cnt == 0) begin
                    spi_done = 1'b1;
                    resp_cnt = -1;
                end
            end else if (spi_en && (int'(idx) != hold_idx)) begin
                resp_cnt = 3;
            end
        end
    end

    initial begin
        s_spi_done = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            s_spi_done = s_pend;
            s_pend = s_spi_en;
        end
    end

    task automatic strobe(input logic [2:0] cmd);
        mlc_cmd = cmd;
        mlc_en  = 1'b1;
        @(negedge clk);
        mlc_en  = 1'b0;
    endtask

    task automatic wait_write(input int n);
        int cyc;
        for (cyc = 0; cyc < 600; cyc++) begin
            if (spi_en && (idx == 6'(n))) break;
            @(negedge clk);
        end
        checks++;
        if (cyc >= 600) begin
            errors++;
            $display("FAIL wait_write timeout: idx %0d never written, required write within 600 cycles", n);
        end
    endtask

    task automatic count_writes(input int exp_n);
        int n = 0;
        int last = -100;
        int cyc;
        for (cyc = 0; cyc < 3000 && !mlc_idle; cyc++) begin
            if (spi_en) begin
                checks++;
                if (idx !== 6'(n) || spi_addr !== 5'(n) || spi_data !== {2'b10, 6'(n)} || spi_rd_wr !== 1'b0) begin
                    errors++;
                    $display("FAIL cfg_write #%0d: idx=%0d addr=%0d data=%h rd_wr=%b, required idx=%0d addr=%0d data=%h rd_wr=0",
                             n, idx, spi_addr, spi_data, spi_rd_wr, n, 5'(n), {2'b10, 6'(n)});
                end
                if (n > 0) begin
                    checks++;
                    if (cyc - last != 4) begin
                        errors++;
                        $display("FAIL cfg_gap #%0d: %0d cycles between starts, required 4", n, cyc - last);
                    end
                end
                last = cyc;
                n++;
            end
            @(negedge clk);
        end
        checks++;
        if (n != exp_n || mlc_state !== 3'd3) begin
            errors++;
            $display("FAIL cfg_count: %0d writes state=%0d, required %0d writes state=3", n, mlc_state, exp_n);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        checks++;
        if (mlc_state !== 3'd0 || rail_en !== 2'b00 || spi_en !== 1'b0 || spi_rd_wr !== 1'b0 ||
            sh_r !== 1'b0 || fault !== 1'b0 || idx !== 6'd0 || mlc_idle !== 1'b0) begin
            errors++;
            $display("FAIL reset: state=%0d rail=%b spi_en=%b rd_wr=%b sh_r=%b fault=%b idx=%0d idle=%b, required all 0",
                     mlc_state, rail_en, spi_en, spi_rd_wr, sh_r, fault, idx, mlc_idle);
        end
    endtask

    task automatic test_small;
        logic [3:0] exp_rail;
        int n = 0;
        s_cmd = 3'b000;
        s_en  = 1'b1;
        @(negedge clk);
        s_en  = 1'b0;
        for (int c = 0; c <= 5; c++) begin
            exp_rail = 4'b0000;
            for (int k = 0; k < 4; k++) if (c >= k + 2) exp_rail[k] = 1'b1;
            checks++;
            if (s_rail !== exp_rail || s_state !== ((c == 5) ? 3'd2 : 3'd1)) begin
                errors++;
                $display("FAIL small_power cyc=%0d: state=%0d rail=%b, required state=%0d rail=%b",
                         c, s_state, s_rail, (c == 5) ? 2 : 1, exp_rail);
            end
            if (c < 5) @(negedge clk);
        end
        for (int cyc = 0; cyc < 100 && !s_idle; cyc++) begin
            if (s_spi_en) begin
                checks++;
                if (s_idx !== 6'(n)) begin
                    errors++;
                    $display("FAIL small_write #%0d: idx=%0d, required %0d", n, s_idx, n);
                end
                n++;
            end
            @(negedge clk);
        end
        checks++;
        if (n != 3 || s_state !== 3'd3) begin
            errors++;
            $display("FAIL small_count: %0d writes state=%0d, required 3 writes state=3", n, s_state);
        end
    endtask

    task automatic test_power_config;
        logic [1:0] exp_rail;
        logic [2:0] exp_st;
        strobe(3'b000);
        for (int c = 0; c <= 6; c++) begin
            exp_rail = (c >= 5) ? 2'b11 : (c >= 3) ? 2'b01 : 2'b00;
            exp_st   = (c == 6) ? 3'd2 : 3'd1;
            checks++;
            if (rail_en !== exp_rail || mlc_state !== exp_st) begin
                errors++;
                $display("FAIL power_seq cyc=%0d: state=%0d rail=%b, required state=%0d rail=%b",
                         c, mlc_state, rail_en, exp_st, exp_rail);
            end
            if (c < 6) @(negedge clk);
        end
        count_writes(55);
        checks++;
        if (mlc_idle !== 1'b1) begin
            errors++;
            $display("FAIL idle_flag: mlc_idle=%b, required 1", mlc_idle);
        end
    endtask

    task automatic test_capture;
        logic exp_sh;
        strobe(3'b010);
        checks++;
        if (mlc_state !== 3'd4 || spi_en !== 1'b1 || idx !== 6'd61 || spi_addr !== 5'd29 || spi_data !== 8'hBD) begin
            errors++;
            $display("FAIL cap_arm: state=%0d spi_en=%b idx=%0d addr=%0d data=%h, required 4 1 61 29 bd",
                     mlc_state, spi_en, idx, spi_addr, spi_data);
        end
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            checks++;
            if (spi_en !== 1'b0 || mlc_state !== 3'd4 || sh_r !== 1'b0) begin
                errors++;
                $display("FAIL cap_wait cyc=%0d: spi_en=%b state=%0d sh_r=%b, required 0 4 0", c, spi_en, mlc_state, sh_r);
            end
        end
        rx_if_rdy = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            exp_sh = (k % 2 == 0);
            checks++;
            if (sh_r !== exp_sh) begin
                errors++;
                $display("FAIL cap_shift #%0d: sh_r=%b, required %b", k, sh_r, exp_sh);
            end
        end
        rx_if_rdy = 1'b0;
        cap_done  = 1'b1;
        @(negedge clk);
        cap_done  = 1'b0;
        checks++;
        if (mlc_state !== 3'd2 || sh_r !== 1'b0 || spi_en !== 1'b1 || idx !== 6'd0) begin
            errors++;
            $display("FAIL cap_reconfig: state=%0d sh_r=%b spi_en=%b idx=%0d, required 2 0 1 0", mlc_state, sh_r, spi_en, idx);
        end
        count_writes(55);
    endtask

    task automatic test_stop_with_cap_done;
        strobe(3'b010);
        repeat (4) @(negedge clk);
        rx_if_rdy = 1'b1;
        @(negedge clk);
        rx_if_rdy = 1'b0;
        checks++;
        if (sh_r !== 1'b1 || mlc_state !== 3'd4) begin
            errors++;
            $display("FAIL stop_pre: sh_r=%b state=%0d, required 1 4", sh_r, mlc_state);
        end
        mlc_cmd  = 3'b011;
        mlc_en   = 1'b1;
        cap_done = 1'b1;
        @(negedge clk);
        mlc_en   = 1'b0;
        cap_done = 1'b0;
        checks++;
        if (mlc_state !== 3'd3 || sh_r !== 1'b0 || spi_en !== 1'b0 || mlc_idle !== 1'b1) begin
            errors++;
            $display("FAIL stop_and_done: state=%0d sh_r=%b spi_en=%b idle=%b, required 3 0 0 1",
                     mlc_state, sh_r, spi_en, mlc_idle);
        end
    endtask

    task automatic test_fault;
        int cnt = 0;
        hold_idx = 20;
        strobe(3'b001);
        checks++;
        if (mlc_state !== 3'd0) begin
            errors++;
            $display("FAIL off_from_idle: state=%0d, required 0", mlc_state);
        end
        strobe(3'b000);
        wait_write(20);
        while (mlc_state !== 3'd5 && cnt < 1200) begin
            @(negedge clk);
            cnt++;
        end
        checks++;
        if (cnt != 1024) begin
            errors++;
            $display("FAIL fault_latency: FAULT after %0d cycles, required 1024", cnt);
        end
        checks++;
        if (fault !== 1'b1 || rail_en !== 2'b00 || spi_en !== 1'b0 || mlc_idle !== 1'b0) begin
            errors++;
            $display("FAIL fault_outputs: fault=%b rail=%b spi_en=%b idle=%b, required 1 00 0 0", fault, rail_en, spi_en, mlc_idle);
        end
        strobe(3'b000);
        checks++;
        if (mlc_state !== 3'd5 || fault !== 1'b1) begin
            errors++;
            $display("FAIL fault_sticky: state=%0d fault=%b, required 5 1", mlc_state, fault);
        end
        hold_idx = -1;
        strobe(3'b001);
        checks++;
        if (mlc_state !== 3'd0 || fault !== 1'b0) begin
            errors++;
            $display("FAIL fault_exit: state=%0d fault=%b, required 0 0", mlc_state, fault);
        end
    endtask

    task automatic test_off_with_done;
        int bad = 0;
        strobe(3'b000);
        wait_write(5);
        checks++;
        if (rail_en !== 2'b11) begin
            errors++;
            $display("FAIL off_pre: rail=%b, required 11", rail_en);
        end
        repeat (3) @(negedge clk);
        mlc_cmd = 3'b001;
        mlc_en  = 1'b1;
        @(negedge clk);
        mlc_en  = 1'b0;
        checks++;
        if (mlc_state !== 3'd0 || rail_en !== 2'b00 || spi_en !== 1'b0) begin
            errors++;
            $display("FAIL off_vs_done: state=%0d rail=%b spi_en=%b, required 0 00 0", mlc_state, rail_en, spi_en);
        end
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (spi_en !== 1'b0 || mlc_state !== 3'd0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL off_quiet: %0d cycles with activity after OFF, required 0", bad);
        end
    endtask

    task automatic test_reset_mid_config;
        int bad = 0;
        strobe(3'b000);
        wait_write(2);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (mlc_state !== 3'd0 || rail_en !== 2'b00 || spi_en !== 1'b0 || spi_rd_wr !== 1'b0 ||
            sh_r !== 1'b0 || fault !== 1'b0 || idx !== 6'd0 || mlc_idle !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: state=%0d rail=%b spi_en=%b sh_r=%b fault=%b idx=%0d idle=%b, required all 0",
                     mlc_state, rail_en, spi_en, sh_r, fault, idx, mlc_idle);
        end
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (spi_en !== 1'b0 || mlc_state !== 3'd0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL reset_late_done: %0d cycles with activity after reset, required 0", bad);
        end
    endtask

    initial begin
        test_reset();
        test_small();
        test_power_config();
        test_capture();
        test_stop_with_cap_done();
        test_fault();
        test_off_with_done();
        test_reset_mid_config();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation exceeded 2 ms, required completion");
        $fatal(1);
    end

endmodule
